// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
//
// Hazard and sequencing controller for the 5-stage pipeline. It drives the
// enable, bubble and flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB
// latches and the PC. It resolves instruction and data memory waits, load-use
// hazards, taken branches and jumps, and the halt drain.
//
// Parameters
//   DRAIN_CYCLES  cycles spent draining after a halt reaches MEM (1..7)
//   CNT_W         width of the performance counters
//
// Optional feature (macro PIPELINE_CTRL_PERF_EN)
//   Adds stall_cnt, flush_cnt and luse_cnt saturating performance counters.
//
// Ports
//   CLK, nRST             clock (rising edge), async active-low reset
//   ihit, dhit            instruction fetch / data access complete this cycle
//   mem_dren, mem_dwen    MEM-stage instruction reads / writes memory
//   mem_halt              halt instruction is in MEM
//   mem_brtaken           branch / jump-register resolved taken in MEM
//   id_jump               J/JAL decoded in ID
//   id_rs, id_rt          ID source registers
//   id_use_rs, id_use_rt  ID instruction reads rs / rt
//   ex_dren, ex_wsel      EX instruction is a load, and its destination
//   pc_en                 PC update enable
//   ifid_en, ifid_flush   IF/ID enable, IF/ID loads a nop
//   idex_en, idex_noop    ID/EX enable (ieen), ID/EX loads a bubble (noop_i)
//   exmem_en, exmem_flush EX/MEM enable, EX/MEM loads a bubble
//   memwb_en              MEM/WB enable
//   halted                CPU halted
// -----------------------------------------------------------------------------
module pipeline_ctrl #(
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       ihit,
    input  logic       dhit,
    input  logic       mem_dren,
    input  logic       mem_dwen,
    input  logic       mem_halt,
    input  logic       mem_brtaken,
    input  logic       id_jump,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       ex_dren,
    input  logic [4:0] ex_wsel,
    output logic       pc_en,
    output logic       ifid_en,
    output logic       ifid_flush,
    output logic       idex_en,
    output logic       idex_noop,
    output logic       exmem_en,
    output logic       exmem_flush,
    output logic       memwb_en,
    output logic       halted
`ifdef PIPELINE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] luse_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DWAIT,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_noop;
        logic exmem_en;
        logic exmem_flush;
        logic memwb_en;
        logic halted;
    } ctrl_t;

    localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

    state_t     state;
    logic [2:0] drain_cnt;
    logic       flush_pend;   // taken branch seen, IF/ID and ID/EX flush still owed

    logic  dwait;
    logic  luse;
    logic  flush_req;
    logic  run_rules;
    ctrl_t ctrl;

    assign dwait = (mem_dren | mem_dwen) & ~dhit;

    // Register 0 is hard-wired, so a load targeting it can never be a hazard.
    assign luse = ex_dren & (ex_wsel != 5'd0) &
                  ((id_use_rs & (id_rs == ex_wsel)) | (id_use_rt & (id_rt == ex_wsel)));

    assign flush_req = mem_brtaken | flush_pend;

    // The normal RUN hazard ladder (branch, load-use, fetch) applies in RUN once
    // halt and data wait are ruled out, and also on the cycle a data wait
    // releases: that way a branch or load-use waiting behind the data access is
    // resolved in the same cycle the pipeline starts moving again.
    assign run_rules = ((state == ST_RUN) & ~mem_halt & ~dwait) |
                       ((state == ST_DWAIT) & dhit);

    always_comb begin
        // NOTE: every field gets a default first so no path can infer a latch.
        ctrl = '0;

        unique case (state)
            ST_RUN:    ctrl.memwb_en = mem_halt;   // halt lets only MEM/WB advance
            ST_DWAIT:  ;                           // frozen until dhit
            ST_DRAIN:  ctrl.memwb_en = 1'b1;
            ST_HALTED: ctrl.halted   = 1'b1;
            default:   ;
        endcase

        if (run_rules) begin
            if (flush_req) begin
                // The branch leaves MEM now; the front end is only redirected
                // once the fetch completes, otherwise the flush stays pending.
                ctrl.exmem_en    = 1'b1;
                ctrl.memwb_en    = 1'b1;
                ctrl.exmem_flush = 1'b1;
                if (ihit) begin
                    ctrl.pc_en      = 1'b1;
                    ctrl.ifid_en    = 1'b1;
                    ctrl.idex_en    = 1'b1;
                    ctrl.ifid_flush = 1'b1;
                    ctrl.idex_noop  = 1'b1;
                end
            end else if (luse || !ihit) begin
                // Hold the front end and send a bubble down from ID/EX.
                ctrl.idex_en   = 1'b1;
                ctrl.idex_noop = 1'b1;
                ctrl.exmem_en  = 1'b1;
                ctrl.memwb_en  = 1'b1;
            end else begin
                ctrl.pc_en      = 1'b1;
                ctrl.ifid_en    = 1'b1;
                ctrl.idex_en    = 1'b1;
                ctrl.exmem_en   = 1'b1;
                ctrl.memwb_en   = 1'b1;
                ctrl.ifid_flush = id_jump;
            end
        end
    end

    // Reset forces every control low immediately, independent of state.
    assign pc_en       = ctrl.pc_en       & nRST;
    assign ifid_en     = ctrl.ifid_en     & nRST;
    assign ifid_flush  = ctrl.ifid_flush  & nRST;
    assign idex_en     = ctrl.idex_en     & nRST;
    assign idex_noop   = ctrl.idex_noop   & nRST;
    assign exmem_en    = ctrl.exmem_en    & nRST;
    assign exmem_flush = ctrl.exmem_flush & nRST;
    assign memwb_en    = ctrl.memwb_en    & nRST;
    assign halted      = ctrl.halted      & nRST;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= ST_RUN;
            drain_cnt  <= '0;
            flush_pend <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            unique case (state)
                ST_RUN: begin
                    if (mem_halt) begin
                        state      <= ST_DRAIN;
                        drain_cnt  <= DRAIN_LOAD;
                        flush_pend <= 1'b0;
                    end else if (dwait) begin
                        state <= ST_DWAIT;
                    end else if (flush_req) begin
                        flush_pend <= ~ihit;
                    end
                end
                ST_DWAIT: begin
                    if (dhit) begin
                        state <= ST_RUN;
                        if (flush_req) flush_pend <= ~ihit;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == 3'd0) state <= ST_HALTED;
                    else drain_cnt <= drain_cnt - 3'd1;
                end
                ST_HALTED: ;
                default:   state <= ST_RUN;
            endcase
        end
    end

`ifdef PIPELINE_CTRL_PERF_EN
    logic stall_evt;
    logic flush_evt;
    logic luse_evt;

    assign stall_evt = ((state == ST_RUN) | (state == ST_DWAIT)) & ~ctrl.pc_en;
    // A pending flush is the same branch, so only its first cycle counts.
    assign flush_evt = run_rules & flush_req & ~flush_pend;
    assign luse_evt  = run_rules & ~flush_req & luse;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            luse_cnt  <= '0;
        end else if (state != ST_HALTED) begin
            if (stall_evt && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_evt && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
            if (luse_evt  && (luse_cnt  != '1)) luse_cnt  <= luse_cnt  + CNT_W'(1);
        end
    end
`endif

endmodule
